// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared debug-port constants and scanner FSM state type
package debug_pkg;

    // Debug port geometry shared with the mips core
    localparam int DEBUG_ADDR_W = 7;
    localparam int DEBUG_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STEP    = 3'd1,
        ST_SETADDR = 3'd2,
        ST_WAIT    = 3'd3,
        ST_PUSH    = 3'd4
    } dbg_state_t;

endpackage

// File: rtl/debug_scanner_if.sv
// rtl/debug_scanner_if.sv - captured-word stream from the scanner to its sink
interface debug_scanner_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output addr, output data, output last, input ready);
    modport slave  (input valid, input addr, input data, input last, output ready);
endinterface

// File: rtl/debug_pulse_gen.sv
// rtl/debug_pulse_gen.sv - STEP_W-cycle step pulse followed by one low gap cycle
module debug_pulse_gen #(
    parameter int STEP_W = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic trig_i,
    output logic pulse_o,
    output logic done_o
);
    localparam int CNT_W = $clog2(STEP_W + 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count STEP_W pulse cycles then one gap cycle; done marks the gap cycle
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (trig_i && !active_q) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == CNT_W'(STEP_W)) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse_o = active_q && (cnt_q < CNT_W'(STEP_W));
    assign done_o  = active_q && (cnt_q == CNT_W'(STEP_W));

endmodule

// File: rtl/debug_scanner.sv
// rtl/debug_scanner.sv - host-side debug master: halt, single-step and register scan (trace mode: DEBUG_SCANNER_AUTOSCAN_EN)
module debug_scanner
    import debug_pkg::*;
#(
    parameter int ADDR_W   = DEBUG_ADDR_W,
    parameter int DATA_W   = DEBUG_DATA_W,
    parameter int NUM_REGS = 128,
    parameter int READ_LAT = 1,
    parameter int STEP_W   = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              halt_i,
    input  logic              step_req_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              debug_en_o,
    output logic              debug_step_o,
    output logic [ADDR_W-1:0] debug_addr_o,
    input  logic [DATA_W-1:0] debug_data_i,
    debug_scanner_if.master   out_if
);
    localparam int LAT_W = $clog2(READ_LAT + 1);

    dbg_state_t        state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              en_q;
    logic              ov_q, ov_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic              olast_q, olast_d;
    logic              step_go;
    logic              step_pulse;
    logic              step_done;

    debug_pulse_gen #(
        .STEP_W (STEP_W)
    ) u_pulse (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .trig_i  (step_go),
        .pulse_o (step_pulse),
        .done_o  (step_done)
    );

    // Debug enable simply follows halt one cycle later, whatever the FSM does
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            en_q <= 1'b0;
        end else begin
            en_q <= halt_i;
        end
    end

    // Next-state logic: step handling, scan sequencing and pending-start bookkeeping
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        ov_d    = ov_q;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        olast_d = olast_q;
        step_go = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (step_req_i && en_q) begin
                    state_d = ST_STEP;
                    step_go = 1'b1;
                end else if (start_i || pend_q) begin
                    state_d = ST_SETADDR;
                    addr_d  = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_STEP: begin
                if (step_done) begin
                    state_d = ST_IDLE;
`ifdef DEBUG_SCANNER_AUTOSCAN_EN
                    pend_d  = 1'b1;
`endif
                end
            end
            ST_SETADDR: begin
                lat_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(READ_LAT - 1)) begin
                    ov_d    = 1'b1;
                    oaddr_d = addr_q;
                    odata_d = debug_data_i;
                    olast_d = (addr_q == ADDR_W'(NUM_REGS - 1));
                    state_d = ST_PUSH;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_PUSH: begin
                if (ov_q && out_if.ready) begin
                    ov_d = 1'b0;
                    if (olast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_SETADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A start that cannot be served this cycle (busy, or losing to a step) is remembered once
        if (start_i && (state_q != ST_IDLE || state_d == ST_STEP)) begin
            pend_d = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            addr_q  <= '0;
            lat_q   <= '0;
            ov_q    <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            ov_q    <= ov_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            olast_q <= olast_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign debug_en_o   = en_q;
    assign debug_step_o = step_pulse;
    assign debug_addr_o = addr_q;
    assign out_if.valid = ov_q;
    assign out_if.addr  = oaddr_q;
    assign out_if.data  = odata_q;
    assign out_if.last  = olast_q;

endmodule

// File: tb/tb_debug_scanner.sv
// tb/tb_debug_scanner.sv - directed scoreboard bench for debug_scanner
module tb_debug_scanner;
    import debug_pkg::*;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int RL = 1;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          halt = 1'b0;
    logic          step_req = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          dbg_en;
    logic          dbg_step;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data = '0;

    debug_scanner_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();

    debug_scanner #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .READ_LAT(RL), .STEP_W(SW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .halt_i       (halt),
        .step_req_i   (step_req),
        .start_i      (start),
        .busy_o       (busy),
        .debug_en_o   (dbg_en),
        .debug_step_o (dbg_step),
        .debug_addr_o (dbg_addr),
        .debug_data_i (dbg_data),
        .out_if       (sif.master)
    );

    always #5 clk = ~clk;

    // Core register file model: value = addr*16, visible one cycle after the address changes
    always @(posedge clk) dbg_data <= DW'(dbg_addr) << 4;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    word_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    n_words = 0;
    int    last_hs = -1;
    bit    rate_chk = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_scan();
        for (int i = 0; i < NR; i++) begin
            word_t w;
            w.a = AW'(i);
            w.d = DW'(i) * 16;
            w.l = (i == NR - 1);
            sb.push_back(w);
        end
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step_req = 1'b1;
        @(posedge clk); #1 step_req = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        chk(tag, 64'(!busy && sb.size() == 0), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_debug_en"}, 64'(dbg_en), 0);
        chk({tag, "_debug_step"}, 64'(dbg_step), 0);
        chk({tag, "_debug_addr"}, 64'(dbg_addr), 0);
        chk({tag, "_out_valid"}, 64'(sif.valid), 0);
        chk({tag, "_out_addr"}, 64'(sif.addr), 0);
        chk({tag, "_out_data"}, 64'(sif.data), 0);
        chk({tag, "_out_last"}, 64'(sif.last), 0);
    endtask

    // Scoreboard: every accepted word must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && sif.valid && sif.ready) begin
            word_t w;
            n_words++;
            chk("word_expected", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                w = sb.pop_front();
                chk("out_addr", 64'(sif.addr), 64'(w.a));
                chk("out_data", 64'(sif.data), 64'(w.d));
                chk("out_last", 64'(sif.last), 64'(w.l));
            end
            if (rate_chk && last_hs >= 0 && sif.addr != '0)
                chk("word_rate", 64'(cyc - last_hs), 2 + RL);
            last_hs = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int step_cnt, busy_cnt, n0, found;
        sif.ready = 1'b1;

        // Reset state, with halt already requested
        halt = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Halted single step
        repeat (2) @(negedge clk);
        chk("debug_en_follows_halt", 64'(dbg_en), 1);
        pulse_step();
        step_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            step_cnt += int'(dbg_step);
            busy_cnt += int'(busy);
        end
        chk("step_high_cycles", 64'(step_cnt), SW);
        chk("step_busy_cycles", 64'(busy_cnt), SW + 1);

        // Step request in run mode is dropped
        @(posedge clk); #1 halt = 1'b0;
        repeat (2) @(negedge clk);
        chk("debug_en_low", 64'(dbg_en), 0);
        pulse_step();
        step_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            step_cnt += int'(dbg_step);
            busy_cnt += int'(busy);
        end
        chk("runmode_step_high", 64'(step_cnt), 0);
        chk("runmode_busy", 64'(busy_cnt), 0);

        // Plain scan with sink always ready
        @(posedge clk); #1 halt = 1'b1;
        repeat (2) @(negedge clk);
        push_scan();
        pulse_start();
        wait_idle(100, "scan1_done");
        repeat (10) @(negedge clk);
        chk("scan1_words", 64'(n_words), NR);

        // Back-pressure on word 2
        rate_chk = 1'b0;
        push_scan();
        pulse_start();
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (sif.valid && sif.addr == AW'(1)) found = 1;
        end
        chk("reach_word1", 64'(found), 1);
        @(posedge clk); #1 sif.ready = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (sif.valid) found = 1;
        end
        chk("reach_word2", 64'(found), 1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 64'(sif.valid), 1);
            chk("stall_addr", 64'(sif.addr), 2);
            chk("stall_data", 64'(sif.data), 64'h20);
            @(negedge clk);
        end
        @(posedge clk); #1 sif.ready = 1'b1;
        wait_idle(100, "scan2_done");
        repeat (10) @(negedge clk);
        chk("scan2_words", 64'(n_words), 2 * NR);
        rate_chk = 1'b1;

        // Step and start together: step first, then scan; two starts mid-scan collapse into one
        push_scan();
        @(posedge clk); #1 step_req = 1'b1; start = 1'b1;
        @(posedge clk); #1 step_req = 1'b0; start = 1'b0;
        step_cnt = 0; found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge clk);
            step_cnt += int'(dbg_step);
            if (sif.valid) found = 1;
        end
        chk("scan_after_step", 64'(found), 1);
        chk("step_before_scan", 64'(step_cnt), SW);
        push_scan();
        pulse_start();
        pulse_start();
        wait_idle(200, "scan34_done");
        repeat (20) @(negedge clk);
        chk("scan34_words", 64'(n_words), 4 * NR);

        // Trace mode: each step followed by a scan only when the feature is built in
        n0 = n_words;
`ifdef DEBUG_SCANNER_AUTOSCAN_EN
        push_scan();
`endif
        pulse_step();
        wait_idle(100, "auto1_done");
        repeat (5) @(negedge clk);
`ifdef DEBUG_SCANNER_AUTOSCAN_EN
        push_scan();
`endif
        pulse_step();
        wait_idle(100, "auto2_done");
        repeat (20) @(negedge clk);
`ifdef DEBUG_SCANNER_AUTOSCAN_EN
        chk("autoscan_words", 64'(n_words - n0), 2 * NR);
`else
        chk("autoscan_words", 64'(n_words - n0), 0);
`endif

        // Asynchronous reset while waiting on address 2
        push_scan();
        pulse_start();
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            @(negedge clk);
            if (busy && dbg_addr == AW'(2)) found = 1;
        end
        chk("reach_addr2", 64'(found), 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk_all_zero("midscan_reset");
        chk("words_left_at_reset", 64'(sb.size()), 2);
        sb.delete();
        n0 = n_words;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_idle", 64'(busy), 0);
        chk("post_reset_no_words", 64'(n_words - n0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
